ps2_keyboard_ascii: RTL and testbench

Upstream character source for the LCD text controller. Receives PS/2 keyboard frames, validates them, and tracks break, extended and shift state. Translates make codes to ASCII and emits one-cycle write_en/data pulses that drive the LCD controller's write_en/data inputs directly. Enter produces 0x0D, which the LCD controller uses to restart its line.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_scan_to_ascii.sv | 67 ++++++
 rtl/ps2_keyboard_ascii.sv | 157 +++++++++++++++
 tb/tb_ps2_keyboard_ascii.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard front end.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, RECV, CHECK} rx_state_e;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] ASCII_CR  = 8'h0D;

  // data_par = {parity, data[7:0]}; odd parity means the XOR of all nine is 1.
  function automatic logic frame_ok(input logic [8:0] data_par, input logic stop);
    return (^data_par) & stop;
  endfunction

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// Set-2 make code to ASCII lookup; purely combinational.
module ps2_scan_to_ascii
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii,
  output logic       valid
);

  logic [7:0] base;
  logic [7:0] alt;

  always_comb begin
    base  = 8'h00;
    alt   = 8'h00;
    valid = 1'b1;
    case (code)
      8'h15: begin base = "q"; alt = "Q"; end
      8'h1D: begin base = "w"; alt = "W"; end
      8'h24: begin base = "e"; alt = "E"; end
      8'h2D: begin base = "r"; alt = "R"; end
      8'h2C: begin base = "t"; alt = "T"; end
      8'h35: begin base = "y"; alt = "Y"; end
      8'h3C: begin base = "u"; alt = "U"; end
      8'h43: begin base = "i"; alt = "I"; end
      8'h44: begin base = "o"; alt = "O"; end
      8'h4D: begin base = "p"; alt = "P"; end
      8'h1C: begin base = "a"; alt = "A"; end
      8'h1B: begin base = "s"; alt = "S"; end
      8'h23: begin base = "d"; alt = "D"; end
      8'h2B: begin base = "f"; alt = "F"; end
      8'h34: begin base = "g"; alt = "G"; end
      8'h33: begin base = "h"; alt = "H"; end
      8'h3B: begin base = "j"; alt = "J"; end
      8'h42: begin base = "k"; alt = "K"; end
      8'h4B: begin base = "l"; alt = "L"; end
      8'h1A: begin base = "z"; alt = "Z"; end
      8'h22: begin base = "x"; alt = "X"; end
      8'h21: begin base = "c"; alt = "C"; end
      8'h2A: begin base = "v"; alt = "V"; end
      8'h32: begin base = "b"; alt = "B"; end
      8'h31: begin base = "n"; alt = "N"; end
      8'h3A: begin base = "m"; alt = "M"; end
      8'h16: begin base = "1"; alt = "!"; end
      8'h1E: begin base = "2"; alt = "@"; end
      8'h26: begin base = "3"; alt = "#"; end
      8'h25: begin base = "4"; alt = "$"; end
      8'h2E: begin base = "5"; alt = "%"; end
      8'h36: begin base = "6"; alt = "^"; end
      8'h3D: begin base = "7"; alt = "&"; end
      8'h3E: begin base = "8"; alt = "*"; end
      8'h46: begin base = "9"; alt = "("; end
      8'h45: begin base = "0"; alt = ")"; end
      8'h29: begin base = 8'h20;    alt = 8'h20;    end
      8'h5A: begin base = ASCII_CR; alt = ASCII_CR; end
      8'h66: begin base = 8'h08;    alt = 8'h08;    end
      8'h41: begin base = ","; alt = "<"; end
      8'h49: begin base = "."; alt = ">"; end
      8'h4E: begin base = "-"; alt = "_"; end
      8'h55: begin base = "="; alt = "+"; end
      default: valid = 1'b0;
    endcase
    ascii = shift ? alt : base;
  end

endmodule

// File: rtl/ps2_keyboard_ascii.sv
// PS/2 keyboard receiver: frame capture with parity/stop/timeout checks, then
// break/extended/shift tracking and ASCII write pulses for the LCD controller.
module ps2_keyboard_ascii
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
)(
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       write_en,
  output logic [7:0] data,
  output logic [7:0] scancode,
  output logic       scancode_valid,
  output logic       frame_err,
  output logic       shift_active
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;
  logic fall_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall_d = clk_prev_q & ~clk_s2_q;

  rx_state_e     state_q;
  logic [3:0]    bitcnt_q;
  logic [TW-1:0] tmo_q;
  logic [8:0]    bits_q;
  logic [7:0]    scancode_q;
  logic          scancode_valid_q;
  logic          frame_err_q;

  // The verdict is taken on the stop-bit fall itself, so scancode_valid is
  // high during the single CHECK cycle and the decoder acts one cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      bitcnt_q         <= '0;
      tmo_q            <= '0;
      bits_q           <= '0;
      scancode_q       <= '0;
      scancode_valid_q <= 1'b0;
      frame_err_q      <= 1'b0;
    end else begin
      scancode_valid_q <= 1'b0;
      frame_err_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (fall_d && !dat_s2_q) begin
            state_q  <= RECV;
            bitcnt_q <= '0;
          end
        end
        RECV: begin
          if (fall_d) begin
            tmo_q <= '0;
            if (bitcnt_q == 4'd9) begin
              state_q <= CHECK;
              if (frame_ok(bits_q, dat_s2_q)) begin
                scancode_q       <= bits_q[7:0];
                scancode_valid_q <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
              end
            end else begin
              bits_q   <= {dat_s2_q, bits_q[8:1]};
              bitcnt_q <= bitcnt_q + 4'd1;
            end
          end else if (tmo_q == TMO_LAST) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            tmo_q       <= '0;
            frame_err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        CHECK:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic       brk_q, ext_q, shift_l_q, shift_r_q;
  logic       write_en_q;
  logic [7:0] data_q;
  logic [7:0] key_ascii;
  logic       key_valid;

  ps2_scan_to_ascii u_xlate (
    .code  (scancode_q),
    .shift (shift_l_q | shift_r_q),
    .ascii (key_ascii),
    .valid (key_valid)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      shift_l_q  <= 1'b0;
      shift_r_q  <= 1'b0;
      write_en_q <= 1'b0;
      data_q     <= '0;
    end else begin
      write_en_q <= 1'b0;
      if (scancode_valid_q) begin
        if (scancode_q == SC_BREAK) begin
          brk_q <= 1'b1;
        end else if (scancode_q == SC_EXT) begin
          ext_q <= 1'b1;
        end else begin
          brk_q <= 1'b0;
          ext_q <= 1'b0;
          if (!ext_q && scancode_q == SC_LSHIFT) begin
            shift_l_q <= ~brk_q;
          end else if (!ext_q && scancode_q == SC_RSHIFT) begin
            shift_r_q <= ~brk_q;
          end else if (!brk_q && key_valid && scancode_q != SC_BAT &&
                       (!ext_q || scancode_q == SC_ENTER)) begin
            write_en_q <= 1'b1;
            data_q     <= key_ascii;
          end
        end
      end
    end
  end

  assign write_en       = write_en_q;
  assign data           = data_q;
  assign scancode       = scancode_q;
  assign scancode_valid = scancode_valid_q;
  assign frame_err      = frame_err_q;
  assign shift_active   = shift_l_q | shift_r_q;

endmodule

// File: tb/tb_ps2_keyboard_ascii.sv
// Self-checking bench: directed PS/2 scenarios plus randomized frames against a key-table model.
module tb_ps2_keyboard_ascii;

  localparam int TMO  = 200;
  localparam int HALF = 15;

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       write_en;
  logic [7:0] data;
  logic [7:0] scancode;
  logic       scancode_valid;
  logic       frame_err;
  logic       shift_active;

  always #5 clock = ~clock;

  ps2_keyboard_ascii #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock          (clock),
    .reset          (reset),
    .ps2_clk        (ps2_clk),
    .ps2_dat        (ps2_dat),
    .write_en       (write_en),
    .data           (data),
    .scancode       (scancode),
    .scancode_valid (scancode_valid),
    .frame_err      (frame_err),
    .shift_active   (shift_active)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
  } ev_t;
  ev_t evq[$];

  logic [7:0]   lo_tab[256];
  logic [7:0]   up_tab[256];
  bit           has_key[256];
  logic [7:0]   keys[$];
  bit           m_brk, m_ext, m_shl, m_shr;
  bit           prev_sv;
  bit           exp_we;
  logic [7:0]   exp_data;
  logic [7:0]   last_data = 8'h00;
  int           we_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_key(input logic [7:0] c, input logic [7:0] lo, input logic [7:0] up);
    has_key[c] = 1'b1;
    lo_tab[c]  = lo;
    up_tab[c]  = up;
    keys.push_back(c);
  endtask

  task automatic build_tables();
    logic [7:0] lcodes[26] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44,
                               8'h4D, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42,
                               8'h4B, 8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A};
    logic [7:0] dcodes[10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
    string lets = "qwertyuiopasdfghjklzxcvbnm";
    string digs = "1234567890";
    string sdig = "!@#$%^&*()";
    for (int i = 0; i < 256; i++) begin
      has_key[i] = 1'b0;
      lo_tab[i]  = 8'h00;
      up_tab[i]  = 8'h00;
    end
    for (int i = 0; i < 26; i++) add_key(lcodes[i], lets[i], lets[i] - 8'd32);
    for (int i = 0; i < 10; i++) add_key(dcodes[i], digs[i], sdig[i]);
    add_key(8'h29, 8'h20, 8'h20);
    add_key(8'h5A, 8'h0D, 8'h0D);
    add_key(8'h66, 8'h08, 8'h08);
    add_key(8'h41, 8'h2C, 8'h3C);
    add_key(8'h49, 8'h2E, 8'h3E);
    add_key(8'h4E, 8'h2D, 8'h5F);
    add_key(8'h55, 8'h3D, 8'h2B);
  endtask

  // Keyboard-level model: prefix bytes set flags, everything else consumes them.
  task automatic model_byte(input logic [7:0] b, output bit we, output logic [7:0] d);
    we = 1'b0;
    d  = 8'h00;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      if (!m_ext && b == 8'h12) m_shl = !m_brk;
      else if (!m_ext && b == 8'h59) m_shr = !m_brk;
      else if (!m_brk && has_key[b] && (!m_ext || b == 8'h5A)) begin
        we = 1'b1;
        d  = (m_shl || m_shr) ? up_tab[b] : lo_tab[b];
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  always @(negedge clock) begin
    ev_t ev;
    if (reset) begin
      prev_sv = 1'b0;
    end else begin
      if (prev_sv) begin
        check("write_en_after_scancode", write_en, exp_we);
        if (exp_we) check("data", data, exp_data);
      end else begin
        check("write_en_idle", write_en, 0);
      end
      if (write_en) begin
        last_data = data;
        we_count++;
      end
      check("shift_active", shift_active, m_shl | m_shr);
      prev_sv = 1'b0;
      if (scancode_valid) begin
        if (evq.size() == 0) check("scancode_valid_unexpected", scancode_valid, 0);
        else begin
          ev = evq.pop_front();
          check("scancode_valid_on_frame", scancode_valid, !ev.is_err);
          if (!ev.is_err) begin
            check("scancode", scancode, ev.code);
            model_byte(ev.code, exp_we, exp_data);
            prev_sv = 1'b1;
          end
        end
      end
      if (frame_err) begin
        if (evq.size() == 0) check("frame_err_unexpected", frame_err, 0);
        else begin
          ev = evq.pop_front();
          check("frame_err_on_frame", frame_err, ev.is_err);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic ps2_bit(input logic v);
    ps2_dat = v;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    ev_t ev;
    ev.is_err = bad_par | bad_stop;
    ev.code   = b;
    evq.push_back(ev);
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    ps2_dat = 1'b1;
    tick(HALF);
    check("frame_events_drained", evq.size(), 0);
    evq.delete();
  endtask

  task automatic check_out(input string name, input int base, input int n, input logic [7:0] c);
    check({name, "_count"}, we_count - base, n);
    if (n > 0) check({name, "_char"}, last_data, c);
  endtask

  function automatic logic [7:0] rand_key();
    return keys[$urandom_range(0, keys.size() - 1)];
  endfunction

  initial begin
    #2_000_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    ev_t ev;
    m_brk = 0; m_ext = 0; m_shl = 0; m_shr = 0;
    prev_sv = 0; exp_we = 0; exp_data = 0;
    build_tables();
    check("model_1C_lower", lo_tab[8'h1C], 8'h61);
    check("model_1B_upper", up_tab[8'h1B], 8'h53);
    check("model_45_upper", up_tab[8'h45], 8'h29);

    reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
    #1;
    check("reset_write_en", write_en, 0);
    check("reset_data", data, 0);
    check("reset_scancode", scancode, 0);
    check("reset_scancode_valid", scancode_valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_shift", shift_active, 0);
    tick(4);
    @(negedge clock) reset = 1'b0;
    tick(5);

    base = we_count; send_frame(8'h1C, 0, 0); check_out("t1_a", base, 1, 8'h61);

    base = we_count;
    send_frame(8'h12, 0, 0); check("t2_shift_on", shift_active, 1);
    send_frame(8'h1C, 0, 0); check_out("t2_A", base, 1, 8'h41);
    send_frame(8'hF0, 0, 0); send_frame(8'h1C, 0, 0);
    send_frame(8'hF0, 0, 0); send_frame(8'h12, 0, 0); check("t2_shift_off", shift_active, 0);
    send_frame(8'h1C, 0, 0); check_out("t2_a", base, 2, 8'h61);

    base = we_count; send_frame(8'h16, 1, 0); check_out("t3_badpar", base, 0, 8'h00);
    send_frame(8'h16, 0, 0); check_out("t3_1", base, 1, 8'h31);

    base = we_count;
    send_frame(8'h5A, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'h5A, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0); check_out("t4_enter", base, 2, 8'h0D);
    send_frame(8'h1C, 0, 0); check_out("t4_ext_cleared", base, 3, 8'h61);

    ev.is_err = 1'b1; ev.code = 8'h29; evq.push_back(ev);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i == 0);
    ps2_dat = 1'b1;
    tick(TMO + 30);
    check("t5_timeout_err", evq.size(), 0);
    evq.delete();
    base = we_count; send_frame(8'h29, 0, 0); check_out("t5_space", base, 1, 8'h20);

    send_frame(8'h12, 0, 0);
    send_frame(8'h1C, 0, 0);
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b0);
    ps2_dat = 1'b1; tick(HALF); ps2_clk = 1'b0; tick(3);
    reset = 1'b1;
    #1;
    check("t6_write_en", write_en, 0);
    check("t6_data", data, 0);
    check("t6_scancode", scancode, 0);
    check("t6_scancode_valid", scancode_valid, 0);
    check("t6_frame_err", frame_err, 0);
    check("t6_shift", shift_active, 0);
    ps2_clk = 1'b1; ps2_dat = 1'b1;
    evq.delete();
    m_brk = 0; m_ext = 0; m_shl = 0; m_shr = 0;
    tick(3);
    @(negedge clock) reset = 1'b0;
    tick(5);
    base = we_count; send_frame(8'h1B, 0, 0); check_out("t6_s", base, 1, 8'h73);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0, 1: send_frame(rand_key(), 0, 0);
        2: begin send_frame(8'hF0, 0, 0); send_frame(rand_key(), 0, 0); end
        3: begin
          if ($urandom_range(0, 1) == 1) send_frame(8'hF0, 0, 0);
          send_frame(($urandom_range(0, 1) == 1) ? 8'h12 : 8'h59, 0, 0);
        end
        4: begin
          send_frame(8'hE0, 0, 0);
          send_frame(($urandom_range(0, 1) == 1) ? 8'h5A : rand_key(), 0, 0);
        end
        5: send_frame(8'($urandom_range(0, 255)), 0, 0);
        6: send_frame(8'($urandom_range(0, 255)), 1, 0);
        default: send_frame(8'($urandom_range(0, 255)), 0, 1);
      endcase
    end

    tick(10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
